// File: rtl/wide_word_serializer_pkg.sv
// ----------------------------------------------------------------------------
// wide_word_serializer_pkg
//   Shared definitions for the wide-word serializer:
//     DW_DEFAULT - default output word width
//     state_e    - FSM encoding (ST_IDLE = 0, ST_SEND = 1)
//     clog2      - ceiling log2, usable in constant expressions
//     nwords     - number of DW-bit words needed to carry a W-bit value
// ----------------------------------------------------------------------------
package wide_word_serializer_pkg;

    localparam int DW_DEFAULT = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int power;
        result = 0;
        power  = 1;
        while (power < value) begin
            power  = power * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int nwords(input int width, input int word_width);
        return (width + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/wide_word_serializer.sv
// ----------------------------------------------------------------------------
// wide_word_serializer
//   Captures a W-bit value on a load strobe and emits it as NWORDS words of
//   DW bits over a valid/ready stream, least-significant word first. The top
//   word is zero-padded above bit W-1.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   en       in   load strobe; y_in is captured when the load is accepted
//   y_in     in   [W-1:0]  wide value to serialize
//   busy     out  a word sequence is outstanding
//   x_out    out  [DW-1:0] current output word
//   x_valid  out  x_out holds a valid word
//   x_ready  in   downstream accepts the current word this cycle
//   x_last   out  current word is the final word of the sequence
//   overrun  out  sticky: a load arrived while busy and was dropped
//
// All outputs come straight from flops; en and x_ready only steer next state.
// ----------------------------------------------------------------------------
module wide_word_serializer
    import wide_word_serializer_pkg::*;
#(
    parameter int W  = 98,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  y_in,
    output logic          busy,
    output logic [DW-1:0] x_out,
    output logic          x_valid,
    input  logic          x_ready,
    output logic          x_last,
    output logic          overrun
);

    localparam int NWORDS = nwords(W, DW);
    // Keep the index at least one bit wide so a single-word build still elaborates.
    localparam int IW     = (clog2(NWORDS) < 1) ? 1 : clog2(NWORDS);

    localparam logic [IW-1:0] IDX_ZERO = '0;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic [DW-1:0]   shadow_q [NWORDS];
    logic [DW-1:0]   x_out_q;
    logic            x_valid_q;
    logic            x_last_q;
    logic            overrun_q;

    logic [NWORDS*DW-1:0] y_ext;
    logic [DW-1:0]        y_words [NWORDS];
    logic [IW-1:0]        idx_next;
    logic                 handshake;
    logic                 final_handshake;
    logic                 load_accept;

    // Zero-extend the input so the top word carries zeros above bit W-1.
    always_comb begin
        y_ext          = '0;
        y_ext[W-1:0]   = y_in;
    end

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_split
            assign y_words[gi] = y_ext[gi*DW +: DW];
        end
    endgenerate

    assign handshake       = x_valid_q & x_ready;
    assign final_handshake = handshake & x_last_q;
    // A load is taken when idle, or on the very cycle the last word leaves,
    // which lets back-to-back loads stream without an idle gap.
    assign load_accept     = en & ((state_q == ST_IDLE) | final_handshake);
    assign idx_next        = idx_q + IDX_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_ZERO;
            x_out_q   <= '0;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            if (load_accept) begin
                state_q   <= ST_SEND;
                idx_q     <= IDX_ZERO;
                x_out_q   <= y_words[0];
                x_valid_q <= 1'b1;
                x_last_q  <= (NWORDS == 1);
                overrun_q <= 1'b0;
                for (int i = 0; i < NWORDS; i++) begin
                    shadow_q[i] <= y_words[i];
                end
            end else begin
                // Load arriving mid-sequence is dropped; remember that it happened.
                if (en && (state_q == ST_SEND)) begin
                    overrun_q <= 1'b1;
                end
                if (handshake) begin
                    if (x_last_q) begin
                        state_q   <= ST_IDLE;
                        idx_q     <= IDX_ZERO;
                        x_out_q   <= '0;
                        x_valid_q <= 1'b0;
                        x_last_q  <= 1'b0;
                    end else begin
                        // Present the next word from the shadow copy so the
                        // output word is always a flop, never a live mux.
                        idx_q    <= idx_next;
                        x_out_q  <= shadow_q[idx_next];
                        x_last_q <= (idx_next == IDX_LAST);
                    end
                end
            end
        end
    end

    assign busy    = (state_q == ST_SEND);
    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign x_last  = x_last_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_wide_word_serializer.sv
// ----------------------------------------------------------------------------
// tb_wide_word_serializer
//   Scoreboard bench: expected {last, word} pairs are queued when a load is
//   driven and compared against the stream as words are presented/accepted.
// ----------------------------------------------------------------------------
module tb_wide_word_serializer;

    localparam int W      = 98;
    localparam int DW     = 32;
    localparam int NWORDS = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic [W-1:0]  y_in;
    logic          busy;
    logic [DW-1:0] x_out;
    logic          x_valid;
    logic          x_ready;
    logic          x_last;
    logic          overrun;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int ready_mode = 0;
    int cyc = 0;

    logic [DW:0]   exp_q [$];
    logic [DW-1:0] rx_q  [$];

    wide_word_serializer #(.W(W), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .y_in    (y_in),
        .busy    (busy),
        .x_out   (x_out),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_last  (x_last),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected words: zero-extend to NWORDS*DW and slice LSW first.
    task automatic push_value(input logic [W-1:0] v);
        logic [NWORDS*DW-1:0] ext;
        ext = '0;
        ext[W-1:0] = v;
        for (int i = 0; i < NWORDS; i++) begin
            exp_q.push_back({(i == NWORDS - 1), ext[i*DW +: DW]});
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check_val(tag, {127'd0, (busy || exp_q.size() != 0)}, 128'd0);
    endtask

    // Ready pattern: 0 = always ready, 1 = 1,0,0,1,0,0..., 2 = random.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0:       x_ready = 1'b1;
            1:       x_ready = ((cyc % 3) == 0);
            default: x_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every presented word must match the queue head (this also
    // catches instability during stalls); a handshake retires the head.
    always @(negedge clk) begin
        if (rst === 1'b1 && x_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_valid", 128'd1, 128'd0);
            end else begin
                check_val("word", {96'd0, x_out}, {96'd0, exp_q[0][DW-1:0]});
                check_val("last", {127'd0, x_last}, {127'd0, exp_q[0][DW]});
                if (x_ready) begin
                    $display("word out: %08h last=%0d", x_out, x_last);
                    void'(exp_q.pop_front());
                    rx_q.push_back(x_out);
                    hs_count++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] vc;
        logic [W-1:0] acc;
        logic [127:0] reasm;
        int n;

        rst = 1'b0;
        en = 1'b0;
        y_in = '0;
        x_ready = 1'b1;
        va = {2'h3, 32'h0000000B, 32'h0000000A, 32'h00000009};
        vb = {2'h1, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D};
        vc = {2'h2, 32'h55AA55AA, 32'h0F0F0F0F, 32'hA5A5A5A5};

        // Reset state
        repeat (3) step();
        check_val("rst_valid", {127'd0, x_valid}, 128'd0);
        check_val("rst_busy", {127'd0, busy}, 128'd0);
        check_val("rst_last", {127'd0, x_last}, 128'd0);
        check_val("rst_overrun", {127'd0, overrun}, 128'd0);
        check_val("rst_xout", {96'd0, x_out}, 128'd0);
        rst = 1'b1;
        step();

        // Basic load, ready held high; includes the zero-padded top word
        ready_mode = 0;
        hs_count = 0;
        en = 1'b1; y_in = va; push_value(va);
        step();
        en = 1'b0;
        check_val("latency_valid", {127'd0, x_valid}, 128'd1);
        check_val("latency_busy", {127'd0, busy}, 128'd1);
        wait_drain("drain_basic");
        check_val("basic_busy_fall", {127'd0, busy}, 128'd0);
        check_val("basic_hs", 128'(hs_count), 128'(NWORDS));

        // Same load with stalling downstream
        ready_mode = 1;
        hs_count = 0;
        en = 1'b1; y_in = va; push_value(va);
        step();
        en = 1'b0;
        wait_drain("drain_stall");
        check_val("stall_hs", 128'(hs_count), 128'(NWORDS));

        // Back-to-back load on the final handshake
        ready_mode = 0;
        en = 1'b1; y_in = va; push_value(va);
        step();
        en = 1'b0;
        n = 0;
        while (!(x_valid && x_last) && n < 50) begin
            step();
            n++;
        end
        check_val("b2b_reach_last", {127'd0, (x_valid && x_last)}, 128'd1);
        en = 1'b1; y_in = vb; push_value(vb);
        step();
        en = 1'b0;
        check_val("b2b_valid", {127'd0, x_valid}, 128'd1);
        check_val("b2b_overrun", {127'd0, overrun}, 128'd0);
        check_val("b2b_first_word", {96'd0, x_out}, {96'd0, vb[31:0]});
        wait_drain("drain_b2b");

        // Load during word 1 is dropped and flagged
        en = 1'b1; y_in = va; push_value(va);
        step();
        en = 1'b0;
        step();
        en = 1'b1; y_in = vb;
        step();
        en = 1'b0;
        check_val("ovr_set", {127'd0, overrun}, 128'd1);
        wait_drain("drain_ovr");
        check_val("ovr_held", {127'd0, overrun}, 128'd1);
        en = 1'b1; y_in = vc; push_value(vc);
        step();
        en = 1'b0;
        check_val("ovr_clear", {127'd0, overrun}, 128'd0);
        wait_drain("drain_ovr_clear");

        // Asynchronous reset during word 2
        en = 1'b1; y_in = vb; push_value(vb);
        step();
        en = 1'b1; y_in = vc;
        step();
        en = 1'b0;
        step();
        check_val("pre_rst_word2", {96'd0, x_out}, {96'd0, vb[95:64]});
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_valid", {127'd0, x_valid}, 128'd0);
        check_val("arst_busy", {127'd0, busy}, 128'd0);
        check_val("arst_overrun", {127'd0, overrun}, 128'd0);
        exp_q.delete();
        step();
        rst = 1'b1;
        step();
        ready_mode = 2;
        en = 1'b1; y_in = vc; push_value(vc);
        step();
        en = 1'b0;
        check_val("restart_word0", {96'd0, x_out}, {96'd0, vc[31:0]});
        wait_drain("drain_restart");

        // Accumulator result: sum of 100 random values below 1024
        acc = '0;
        for (int i = 0; i < 100; i++) begin
            acc = acc + W'($urandom_range(0, 1023));
        end
        rx_q.delete();
        ready_mode = 1;
        en = 1'b1; y_in = acc; push_value(acc);
        step();
        en = 1'b0;
        wait_drain("drain_accum");
        check_val("accum_count", 128'(rx_q.size()), 128'(NWORDS));
        if (rx_q.size() == NWORDS) begin
            reasm = {rx_q[3], rx_q[2], rx_q[1], rx_q[0]};
            check_val("accum_reassembled", reasm, 128'(acc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
